ring_osc_freq_counter: RTL and testbench

Measures the frequency of the programmable delay line's ring oscillator by counting rising edges of SMA_CLKOUT, looped back into the FPGA, over a fixed gate window of system clock cycles. It sits directly downstream of the delay line. Each result is a raw edge count, so the team can calibrate delay per code step (period = GATE_CYCLES·T_clk / count) without an external counter. The oscillator input is asynchronous to the system clock and is synchronized inside the block.

---
 rtl/ring_osc_freq_counter.sv | 132 +++++++++++++
 tb/tb_ring_osc_freq_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of osc_in over a gate
// window of GATE_CYCLES clocks. Define RING_OSC_FREQ_COUNTER_CONTINUOUS_EN for back-to-back windows.
//
// state | meaning
// IDLE  | waiting for start (single-shot build only)
// GATE  | gate window open, counting rising edges
// DONE  | one-cycle result slot, freq_valid high
module ring_osc_freq_counter #(
    parameter int GATE_CYCLES = 50000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             osc_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             freq_ovf
);

    localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;
    logic                   rise;

    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_int;
    logic              edge_full;
    logic [CNT_W-1:0]  edge_sum;
    logic              ovf_sum;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q <= synced;
        end
    end

    // Count including this cycle's edge, saturating at all-ones; overflow means an edge was lost.
    assign edge_full = &edge_cnt;
    assign edge_sum  = (rise && !edge_full) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign ovf_sum   = ovf_int | (rise & edge_full);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = GATE;
            GATE: if (gate_cnt == '0) state_next = DONE;
`ifdef RING_OSC_FREQ_COUNTER_CONTINUOUS_EN
            DONE: state_next = GATE;
`else
            DONE: state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Results are registered on the last GATE edge so they are already visible during DONE.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_int    <= 1'b0;
            busy       <= 1'b0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            busy       <= (state_next == GATE);
            case (state)
                IDLE: begin
                    if (start) begin
                        gate_cnt <= GATE_LOAD;
                        edge_cnt <= '0;
                        ovf_int  <= 1'b0;
                    end
                end
                GATE: begin
                    edge_cnt <= edge_sum;
                    ovf_int  <= ovf_sum;
                    if (gate_cnt == '0) begin
                        freq_count <= edge_sum;
                        freq_ovf   <= ovf_sum;
                        freq_valid <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end
`ifdef RING_OSC_FREQ_COUNTER_CONTINUOUS_EN
                DONE: begin
                    // The edge seen in the DONE cycle opens the next window's count.
                    gate_cnt <= GATE_LOAD;
                    edge_cnt <= CNT_W'(rise);
                    ovf_int  <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Bench for ring_osc_freq_counter: a wide (16-bit) and a narrow (4-bit) instance share stimulus;
// expected counts come from a log of the osc_in edges the bench itself generated.
module tb_ring_osc_freq_counter;

    localparam int GATE = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic osc_in = 1'b0;
    logic start = 1'b0;

    logic        busy, valid, ovf;
    logic [15:0] count;
    logic        busy4, valid4, ovf4;
    logic [3:0]  count4;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    int   osc_half = 0;
    logic osc_level = 1'b0;
    int   ph = 0;
    int   caps[$];

    ring_osc_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .osc_in(osc_in), .start(start),
        .busy(busy), .freq_count(count), .freq_valid(valid), .freq_ovf(ovf)
    );

    ring_osc_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .CLOCK_50(clk), .RESET_N(rst_n), .osc_in(osc_in), .start(start),
        .busy(busy4), .freq_count(count4), .freq_valid(valid4), .freq_ovf(ovf4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator source: toggles every osc_half clocks, or holds osc_level when osc_half is 0.
    // Each rising edge is logged with the index of the clock edge that first samples it.
    always @(negedge clk) begin
        logic nv;
        if (osc_half == 0) begin
            nv = osc_level;
        end else begin
            ph = ph + 1;
            if (ph >= osc_half) begin
                ph = 0;
                nv = ~osc_in;
            end else begin
                nv = osc_in;
            end
        end
        if (nv && !osc_in) caps.push_back(cyc + 1);
        osc_in = nv;
    end

    // An edge first sampled at clock e reaches the edge detector at clock e+2.
    function automatic int edges_in(input int a, input int b);
        int n = 0;
        foreach (caps[i]) if (caps[i] + 2 >= a && caps[i] + 2 <= b) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int n;
        n = edges_in(a, b);
        check({tag, "_count16"}, 32'(count), 32'(n));
        check({tag, "_ovf16"}, 32'(ovf), (n > 65535) ? 32'd1 : 32'd0);
        check({tag, "_count4"}, 32'(count4), (n > 15) ? 32'd15 : 32'(n));
        check({tag, "_ovf4"}, 32'(ovf4), (n > 15) ? 32'd1 : 32'd0);
    endtask

    task automatic do_window(input string tag);
        int t, v, bn;
        @(negedge clk);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        v = -1;
        bn = 0;
        for (int i = 0; i < GATE + 20; i++) begin
            if (valid) begin
                v = cyc;
                break;
            end
            if (busy) bn++;
            @(negedge clk);
        end
        check({tag, "_valid_at"}, 32'(v), 32'(t + GATE));
        check({tag, "_busy_cycles"}, 32'(bn), 32'(GATE));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_valid4"}, 32'(valid4), 32'd1);
        check_result(tag, t + 1, t + GATE);
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t, nv, sum, vexp, prev_end;
        int vt[4];

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        rst_n = 1'b1;

`ifdef RING_OSC_FREQ_COUNTER_CONTINUOUS_EN
        osc_half = 2;
        repeat ($urandom_range(5, 20)) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        prev_end = t;
        sum = 0;
        for (int k = 0; k < 10; k++) begin
            int v;
            vexp = t + GATE + k * (GATE + 1);
            v = -1;
            for (int i = 0; i < GATE + 20; i++) begin
                if (valid) begin
                    v = cyc;
                    break;
                end
                @(negedge clk);
            end
            check($sformatf("cont%0d_valid_at", k), 32'(v), 32'(vexp));
            check($sformatf("cont%0d_busy_in_done", k), 32'(busy), 32'd0);
            check_result($sformatf("cont%0d", k), prev_end + 1, vexp);
            check($sformatf("cont%0d_range", k), (count >= 24 && count <= 26) ? 32'd1 : 32'd0, 32'd1);
            sum += int'(count);
            prev_end = vexp;
            @(negedge clk);
            check($sformatf("cont%0d_busy_back", k), 32'(busy), 32'd1);
        end
        check("cont_total", 32'(sum), 32'(edges_in(t + 1, prev_end)));
`else
        osc_half = 2;
        repeat (10) @(negedge clk);
        do_window("p4");
        check("p4_range", (count >= 24 && count <= 26) ? 32'd1 : 32'd0, 32'd1);
        check("p4_sat4", 32'(count4), 32'd15);
        check("p4_ovf4", 32'(ovf4), 32'd1);

        osc_half = 0;
        osc_level = 1'b0;
        repeat (5) @(negedge clk);
        do_window("hold0");
        check("hold0_zero", 32'(count), 32'd0);
        osc_level = 1'b1;
        repeat (10) @(negedge clk);
        do_window("hold1");
        check("hold1_zero", 32'(count), 32'd0);

        for (int k = 0; k < 4; k++) begin
            osc_half = $urandom_range(2, 6);
            repeat ($urandom_range(3, 20)) @(negedge clk);
            do_window($sformatf("rand%0d", k));
        end

        osc_half = 3;
        repeat (5) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        t = c0 + 1;
        nv = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (valid) begin
                if (nv < 4) vt[nv] = cyc;
                nv++;
            end
        end
        start = 1'b0;
        check("held_valids", 32'(nv), 32'd2);
        check("held_first", 32'(vt[0]), 32'(t + GATE));
        check("held_spacing", 32'(vt[1] - vt[0]), 32'(GATE + 2));
        check_result("held_w1", t + GATE + 2 + 1, t + 2 * GATE + 2);
        repeat (GATE + 10) @(negedge clk);

        osc_half = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ovf", 32'(ovf4), 32'd0);
        nv = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < GATE + 10; i++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        check("mid_no_valid", 32'(nv), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);
        do_window("after_rst");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
